speck_encrypt_core: RTL and testbench

Iterative Speck64/128 encryption datapath; sits directly downstream of the key-schedule block and consumes its flattened round-key bus (rk_flat) plus its busy/done status. It accepts one plaintext block (x,y) via valid/ready, applies one Speck round per clock using rk_flat[i*W +: W], and presents the ciphertext via valid/ready to the UART response path.

---
 rtl/speck_encrypt_core.sv | 164 ++++++++++++++++
 tb/tb_speck_encrypt_core.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speck_encrypt_core.sv
// Iterative Speck64/128 encryption core, one round per clock.
//
// Consumes the flattened round-key bus and status of the upstream key-schedule
// block. Accepts one plaintext block (x, y) through a valid/ready handshake,
// runs ROUNDS rounds using rk[i] = i_rk_flat[i*W +: W], and holds the
// ciphertext on a valid/ready output until the consumer takes it.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rk_flat    round keys, rk[i] = i_rk_flat[i*W +: W]
//   i_ks_busy    key schedule running, round keys not valid
//   i_ks_done    one-cycle pulse, round keys complete
//   o_key_lock   high while a block is being encrypted
//   o_key_ok     a valid key schedule is loaded
//   i_in_valid   plaintext valid
//   o_in_ready   core can accept a plaintext
//   i_pt_x       plaintext high word
//   i_pt_y       plaintext low word
//   o_out_valid  ciphertext valid
//   i_out_ready  consumer accepts the ciphertext
//   o_ct_x       ciphertext high word
//   o_ct_y       ciphertext low word
module speck_encrypt_core #(
  parameter int unsigned W      = 32,
  parameter int unsigned ROUNDS = 27,
  parameter int unsigned ALPHA  = 8,
  parameter int unsigned BETA   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [W*ROUNDS-1:0]   i_rk_flat,
  input  logic                  i_ks_busy,
  input  logic                  i_ks_done,
  output logic                  o_key_lock,
  output logic                  o_key_ok,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [W-1:0]          i_pt_x,
  input  logic [W-1:0]          i_pt_y,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [W-1:0]          o_ct_x,
  output logic [W-1:0]          o_ct_y
);

  localparam int unsigned RW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } state_e;

  state_e        r_state, w_state_d;
  logic [W-1:0]  r_x, w_x_d;
  logic [W-1:0]  r_y, w_y_d;
  logic [RW-1:0] r_round, w_round_d;
  logic [W-1:0]  r_ct_x, w_ct_x_d;
  logic [W-1:0]  r_ct_y, w_ct_y_d;
  logic          r_out_valid, w_out_valid_d;
  logic          r_key_ok, w_key_ok_d;

  logic [W-1:0]  w_rk;
  logic [W-1:0]  w_x_ror;
  logic [W-1:0]  w_y_rol;
  logic [W-1:0]  w_x_new;
  logic [W-1:0]  w_y_new;
  logic          w_last;
  logic          w_in_ready;

  // Round datapath: x' = (ROR(x) + y) ^ rk[round], y' = ROL(y) ^ x'.
  assign w_rk    = i_rk_flat[r_round*W +: W];
  assign w_x_ror = (r_x >> ALPHA) | (r_x << (W - ALPHA));
  assign w_x_new = (w_x_ror + r_y) ^ w_rk;
  assign w_y_rol = (r_y << BETA) | (r_y >> (W - BETA));
  assign w_y_new = w_y_rol ^ w_x_new;
  assign w_last  = (r_round == RW'(ROUNDS - 1));

  // ks_busy gates in_ready combinationally so a rekey blocks intake the same cycle.
  assign w_in_ready = (r_state == StIdle) && r_key_ok && !i_ks_busy;

  always_comb begin
    w_state_d     = r_state;
    w_x_d         = r_x;
    w_y_d         = r_y;
    w_round_d     = r_round;
    w_ct_x_d      = r_ct_x;
    w_ct_y_d      = r_ct_y;
    w_out_valid_d = r_out_valid;

    // ks_done wins over ks_busy when both are seen together.
    if (i_ks_done) begin
      w_key_ok_d = 1'b1;
    end else if (i_ks_busy) begin
      w_key_ok_d = 1'b0;
    end else begin
      w_key_ok_d = r_key_ok;
    end

    unique case (r_state)
      StIdle: begin
        if (i_in_valid && w_in_ready) begin
          w_x_d     = i_pt_x;
          w_y_d     = i_pt_y;
          w_round_d = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        w_x_d     = w_x_new;
        w_y_d     = w_y_new;
        w_round_d = r_round + RW'(1);
        if (w_last) begin
          w_ct_x_d      = w_x_new;
          w_ct_y_d      = w_y_new;
          w_out_valid_d = 1'b1;
          w_round_d     = '0;
          w_state_d     = StHold;
        end
      end
      StHold: begin
        // Ciphertext registers keep their value after the handoff.
        if (i_out_ready) begin
          w_out_valid_d = 1'b0;
          w_state_d     = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_x         <= '0;
      r_y         <= '0;
      r_round     <= '0;
      r_ct_x      <= '0;
      r_ct_y      <= '0;
      r_out_valid <= 1'b0;
      r_key_ok    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_x         <= w_x_d;
      r_y         <= w_y_d;
      r_round     <= w_round_d;
      r_ct_x      <= w_ct_x_d;
      r_ct_y      <= w_ct_y_d;
      r_out_valid <= w_out_valid_d;
      r_key_ok    <= w_key_ok_d;
    end
  end

  assign o_key_lock  = (r_state == StRun);
  assign o_key_ok    = r_key_ok;
  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_ct_x      = r_ct_x;
  assign o_ct_y      = r_ct_y;

endmodule

// File: tb/tb_speck_encrypt_core.sv
// Directed bench for speck_encrypt_core with an expected-ciphertext scoreboard.
module tb_speck_encrypt_core;

  localparam int unsigned W      = 32;
  localparam int unsigned ROUNDS = 27;

  logic                clk;
  logic                rst_n;
  logic [W*ROUNDS-1:0] rk_flat;
  logic                ks_busy;
  logic                ks_done;
  logic                key_lock;
  logic                key_ok;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        pt_x;
  logic [W-1:0]        pt_y;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        ct_x;
  logic [W-1:0]        ct_y;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];
  bit          acc_seen;
  bit          out_seen;

  speck_encrypt_core #(
    .W      (W),
    .ROUNDS (ROUNDS),
    .ALPHA  (8),
    .BETA   (3)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rk_flat   (rk_flat),
    .i_ks_busy   (ks_busy),
    .i_ks_done   (ks_done),
    .o_key_lock  (key_lock),
    .o_key_ok    (key_ok),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_pt_x      (pt_x),
    .i_pt_y      (pt_y),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_ct_x      (ct_x),
    .o_ct_y      (ct_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
    logic [63:0] d;
    d = {v, v} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] v, input int n);
    return ror32(v, 32 - n);
  endfunction

  function automatic logic [W*ROUNDS-1:0] key_sched(input logic [31:0] k3, input logic [31:0] k2,
                                                    input logic [31:0] k1, input logic [31:0] k0);
    logic [W*ROUNDS-1:0] r;
    logic [31:0]         l [ROUNDS+2];
    logic [31:0]         k;
    r    = '0;
    k    = k0;
    l[0] = k1;
    l[1] = k2;
    l[2] = k3;
    for (int i = 0; i < int'(ROUNDS); i++) begin
      r[i*32 +: 32] = k;
      if (i < int'(ROUNDS) - 1) begin
        l[i+3] = (k + ror32(l[i], 8)) ^ 32'(i);
        k      = rol32(k, 3) ^ l[i+3];
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] encrypt(input logic [31:0] px, input logic [31:0] py,
                                          input logic [W*ROUNDS-1:0] rk);
    logic [31:0] x;
    logic [31:0] y;
    x = px;
    y = py;
    for (int i = 0; i < int'(ROUNDS); i++) begin
      x = (ror32(x, 8) + y) ^ rk[i*32 +: 32];
      y = rol32(y, 3) ^ x;
    end
    return {x, y};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sampled on the falling edge: sees exactly what the next rising edge will use.
  task automatic mon();
    logic [63:0] exp;
    acc_seen = 1'b0;
    out_seen = 1'b0;
    if (rst_n === 1'b1) begin
      if (key_lock) chk("ks_during_run", 64'({ks_busy, ks_done}), 64'd0);
      if (out_valid && out_ready) begin
        out_seen = 1'b1;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          exp = sb_q.pop_front();
          chk("ciphertext", {ct_x, ct_y}, exp);
        end
      end
      if (in_valid && in_ready) begin
        acc_seen = 1'b1;
        sb_q.push_back(encrypt(pt_x, pt_y, rk_flat));
      end
    end
  endtask

  // One clock: monitor at negedge, return 1 time unit after the next posedge.
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [31:0] k3, input logic [31:0] k2,
                          input logic [31:0] k1, input logic [31:0] k0);
    rk_flat = key_sched(k3, k2, k1, k0);
    ks_busy = 1'b1;
    repeat (3) step();
    ks_busy = 1'b0;
    ks_done = 1'b1;
    step();
    ks_done = 1'b0;
  endtask

  task automatic send(input logic [31:0] px, input logic [31:0] py);
    bit ok;
    ok       = 1'b0;
    pt_x     = px;
    pt_y     = py;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (acc_seen) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  // Called right after the accept edge; checks the 27-cycle latency.
  task automatic wait_out();
    int lat;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd27);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          bad;
    int          lock_cnt;
    int          nacc;
    int          nout;
    int          t_out [2];
    logic [63:0] held;

    rst_n     = 1'b0;
    rk_flat   = '0;
    ks_busy   = 1'b0;
    ks_done   = 1'b0;
    in_valid  = 1'b0;
    pt_x      = '0;
    pt_y      = '0;
    out_ready = 1'b1;
    #22;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_key_ok", 64'(key_ok), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_key_lock", 64'(key_lock), 64'd0);
    chk("rst_ct", {ct_x, ct_y}, 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("no_key_in_ready", 64'(in_ready), 64'd0);

    // 1. Published test vector
    load_key(32'h1b1a1918, 32'h13121110, 32'h0b0a0908, 32'h03020100);
    chk("key_ok_set", 64'(key_ok), 64'd1);
    chk("ready_after_key", 64'(in_ready), 64'd1);
    send(32'h3b726574, 32'h7475432d);
    chk("lock_in_run", 64'(key_lock), 64'd1);
    wait_out();
    chk("tv_ct", {ct_x, ct_y}, 64'h8c6fa548_454e028b);
    chk("lock_in_hold", 64'(key_lock), 64'd0);
    step();
    chk("tv_handoff_valid", 64'(out_valid), 64'd0);
    chk("tv_ready_after", 64'(in_ready), 64'd1);

    // 2. Backpressure for 10 cycles
    out_ready = 1'b0;
    send(32'h3b726574, 32'h7475432d);
    wait_out();
    held = {ct_x, ct_y};
    chk("bp_ct", held, 64'h8c6fa548_454e028b);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_stable", {ct_x, ct_y}, held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_handoff_seen", 64'(out_seen), 64'd1);
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    chk("bp_ready_after", 64'(in_ready), 64'd1);
    chk("bp_ct_kept", {ct_x, ct_y}, held);

    // 3. No key after reset
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    pt_x     = 32'hdeadbeef;
    pt_y     = 32'h01234567;
    in_valid = 1'b1;
    bad      = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (in_ready || out_valid || acc_seen) bad++;
    end
    chk("nokey_idle", 64'(bad), 64'd0);
    ks_done = 1'b1;
    step();
    ks_done = 1'b0;
    chk("nokey_ready", 64'(in_ready), 64'd1);
    step();
    chk("nokey_accept", 64'(acc_seen), 64'd1);
    chk("nokey_lock", 64'(key_lock), 64'd1);
    in_valid = 1'b0;
    wait_out();
    step();
    chk("nokey_done", 64'(out_seen), 64'd1);

    // 4. Back-to-back with out_ready held high
    pt_x     = 32'h00000000;
    pt_y     = 32'hffffffff;
    in_valid = 1'b1;
    lock_cnt = 0;
    nacc     = 0;
    nout     = 0;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (key_lock) lock_cnt++;
      if (out_seen && nout < 2) begin
        t_out[nout] = c;
        nout++;
      end
      if (acc_seen) begin
        if (nacc == 0) begin
          pt_x = 32'h80000001;
          pt_y = 32'h5a5aa5a5;
        end else begin
          in_valid = 1'b0;
        end
        nacc++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(nacc), 64'd2);
    chk("b2b_outputs", 64'(nout), 64'd2);
    if (nout == 2) chk("b2b_spacing", 64'(t_out[1] - t_out[0]), 64'd29);
    chk("b2b_lock_cycles", 64'(lock_cnt), 64'd54);

    // 5. Reset in the middle of a block
    send(32'hcafef00d, 32'h13572468);
    repeat (13) step();
    chk("mid_lock", 64'(key_lock), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_key_ok", 64'(key_ok), 64'd0);
    chk("mid_idle", 64'(key_lock), 64'd0);
    sb_q.delete();
    step();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    bad      = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (in_ready || acc_seen) bad++;
    end
    chk("mid_wait_key", 64'(bad), 64'd0);
    in_valid = 1'b0;
    load_key(32'h1b1a1918, 32'h13121110, 32'h0b0a0908, 32'h03020100);
    send(32'hcafef00d, 32'h13572468);
    wait_out();
    step();
    chk("mid_recovered", 64'(out_seen), 64'd1);

    // 6. Rekey in IDLE, then ks_busy during HOLD
    ks_busy = 1'b1;
    #1;
    chk("rekey_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("rekey_key_ok", 64'(key_ok), 64'd0);
    ks_busy = 1'b0;
    load_key(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210);
    chk("rekey_ok_back", 64'(key_ok), 64'd1);
    send(32'h3b726574, 32'h7475432d);
    wait_out();
    step();
    chk("rekey_out", 64'(out_seen), 64'd1);

    out_ready = 1'b0;
    send(32'h11112222, 32'h33334444);
    wait_out();
    held    = {ct_x, ct_y};
    ks_busy = 1'b1;
    step();
    chk("hold_busy_key_ok", 64'(key_ok), 64'd0);
    chk("hold_busy_valid", 64'(out_valid), 64'd1);
    chk("hold_busy_ct", {ct_x, ct_y}, held);
    ks_busy   = 1'b0;
    out_ready = 1'b1;
    step();
    chk("hold_busy_delivered", 64'(out_seen), 64'd1);
    chk("hold_busy_no_ready", 64'(in_ready), 64'd0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
